// File: rtl/imem_arbiter.sv
// Instruction SRAM arbiter: shares the single-port i_cache SRAM between the
// CPU fetch path and the program loader. Holds the core in BOOT until the
// loader signals completion, then gives fetch strict priority in RUN.
// Optional macro IMEM_ARB_FAIR_EN adds a loader starvation counter in RUN.

`ifndef IADDR_WIDTH
`define IADDR_WIDTH 12
`endif
`ifndef CHIP_EN
`define CHIP_EN 1'b0
`endif
`ifndef CHIP_WDIS
`define CHIP_WDIS 1'b1
`endif

module imem_arbiter #(
  parameter int unsigned AW       = `IADDR_WIDTH,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_valid,
  output logic [DW-1:0] fetch_data,
  output logic          cpu_hold,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  input  logic          ld_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_ceb,
  output logic          mem_web,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic ChipEn   = `CHIP_EN;
  localparam logic ChipWdis = `CHIP_WDIS;

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e state_q, state_d;
  logic   fetch_valid_q;
  logic   starve;

`ifdef IMEM_ARB_FAIR_EN
  localparam logic [7:0] WaitMax = 8'(MAX_WAIT);
  logic [7:0] wait_q, wait_d;

  assign starve = ld_req && (wait_q == WaitMax);

  // Loader wait counter: counts denied cycles in RUN, saturates at WaitMax.
  always_comb begin
    wait_d = wait_q;
    if (state_q != StRun || !ld_req || ld_gnt) begin
      wait_d = 8'd0;
    end else if (wait_q != WaitMax) begin
      wait_d = wait_q + 8'd1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= 8'd0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Next state: BOOT leaves only on ld_done; RUN is terminal until reset.
  always_comb begin
    state_d = state_q;
    if (state_q == StBoot && ld_done) begin
      state_d = StRun;
    end
  end

  // State and read-valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StBoot;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= fetch_gnt;
    end
  end

  // Grant decode; all grants are forced off while reset is held.
  always_comb begin
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    if (!rst) begin
      if (state_q == StBoot) begin
        ld_gnt = ld_req;
      end else if (starve) begin
        ld_gnt = 1'b1;
      end else begin
        fetch_gnt = fetch_req;
        ld_gnt    = ld_req & ~fetch_req;
      end
    end
  end

  // SRAM port drive; idle bus parks at zero with the chip disabled.
  always_comb begin
    mem_ceb   = ~ChipEn;
    mem_web   = ChipWdis;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetch_gnt) begin
      mem_ceb  = ChipEn;
      mem_addr = fetch_addr;
    end else if (ld_gnt) begin
      mem_ceb   = ChipEn;
      mem_web   = ~ChipWdis;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_valid_q ? mem_rdata : '0;
  assign cpu_hold    = (state_q == StBoot);

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port instruction SRAM between the CPU fetch path and a program-loader write port.
- Sits between the fetch stage (aligned word address out, SRAM control out) and the i_cache SRAM macro.
- Holds the core in a BOOT phase until the loader signals completion, then arbitrates fetch reads against loader writes.
- Drives active-low SRAM controls: ceb/web, `CHIP_EN = 0`, `CHIP_WDIS = 1`.

Parameters:
- AW, `IADDR_WIDTH`, SRAM word address width.
- DW, 32, SRAM data width.
- MAX_WAIT, 8, loader starvation limit in RUN; range 1..255. Used only with IMEM_ARB_FAIR_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch stage requests a read this cycle.
- fetch_addr  in  AW  aligned word address from fetch stage.
- fetch_gnt  out  1  read issued to SRAM this cycle (combinational).
- fetch_valid  out  1  fetch_data valid; registered, one cycle after fetch_gnt.
- fetch_data  out  DW  instruction word; equals mem_rdata when fetch_valid = 1, else 0.
- cpu_hold  out  1  registered; 1 in BOOT, holds PC/core.
- ld_req  in  1  loader write request.
- ld_addr  in  AW  loader word address.
- ld_wdata  in  DW  loader write data.
- ld_gnt  out  1  write issued this cycle (combinational).
- ld_done  in  1  single-cycle pulse: image load complete.
- mem_addr  out  AW  SRAM address.
- mem_wdata  out  DW  SRAM write data.
- mem_ceb  out  1  SRAM chip enable, active low.
- mem_web  out  1  SRAM write enable, active low.
- mem_rdata  in  DW  SRAM read data, 1-cycle latency.

Behaviour:
- State machine, 2 states, registered: BOOT and RUN. Reset value is BOOT.
  - BOOT -> RUN on ld_done = 1 at the clock edge; any write granted in that same cycle still completes.
  - RUN has no exit other than rst.
- Reset values:
  - cpu_hold = 1, fetch_valid = 0, fetch_data = 0.
  - wait_cnt = 0.
  - While rst is high: mem_ceb = 1, mem_web = `CHIP_WDIS`, mem_addr = 0, mem_wdata = 0, ld_gnt = 0, fetch_gnt = 0.
- cpu_hold = 1 exactly while state = BOOT. It drops in the first cycle after the ld_done edge.
- BOOT arbitration:
  - fetch_req is ignored; fetch_gnt = 0.
  - ld_gnt = ld_req.
- RUN arbitration, base behaviour: fetch has strict priority.
  - fetch_gnt = fetch_req.
  - ld_gnt = ld_req & ~fetch_req.
- Memory drive when fetch_gnt = 1: mem_ceb = 0, mem_web = 1, mem_addr = fetch_addr, mem_wdata = 0.
- Memory drive when ld_gnt = 1: mem_ceb = 0, mem_web = 0, mem_addr = ld_addr, mem_wdata = ld_wdata.
- No grant: mem_ceb = 1, mem_web = 1, mem_addr = 0, mem_wdata = 0.
- fetch_gnt and ld_gnt are never both 1.
- Read latency:
  - fetch_valid(t+1) = fetch_gnt(t).
  - fetch_data is combinationally mem_rdata gated by fetch_valid.
  - Back-to-back reads give one word per cycle.
- Same-address read following a write returns the written data (SRAM property; no bypass in this block).
- Reset mid-operation: an in-flight read is dropped, with fetch_valid = 0 in the cycle after rst; state returns to BOOT.
- ld_done while already in RUN: ignored.

Optional Feature:
- Macro: IMEM_ARB_FAIR_EN.
- Defined: adds an 8-bit wait_cnt, RUN only.
  - Increments each cycle ld_req = 1 and ld_gnt = 0, saturating at MAX_WAIT.
  - When wait_cnt == MAX_WAIT and ld_req = 1: ld_gnt = 1 and fetch_gnt = 0 for that cycle; wait_cnt clears on the next edge.
  - wait_cnt also clears whenever ld_req = 0 or ld_gnt = 1.
  - The starved fetch retries; fetch_req is expected to stay asserted.
- Undefined: no counter; strict fetch priority in RUN, so the loader can starve indefinitely.

Test Plan:
- Reset, then BOOT writes: rst high 2 cycles, then ld_req with addr 0x004, data 0x00500093.
  - Expect cpu_hold = 1, ld_gnt = 1, mem_ceb = 0, mem_web = 0, mem_addr = 0x004, mem_wdata = 0x00500093.
  - fetch_req = 1 in BOOT gives fetch_gnt = 0.
- BOOT to RUN: ld_done pulse at cycle N.
  - Expect cpu_hold = 0 from N+1.
  - fetch_req with addr 0x004 at N+1 gives fetch_gnt = 1, mem_web = 1, then fetch_valid = 1 and fetch_data = 0x00500093 at N+2.
- Streaming reads: fetch_req held high for addr 0..3.
  - Expect fetch_valid high 4 consecutive cycles, each one cycle after its grant, data in order.
- Conflict, macro undefined: RUN with fetch_req and ld_req both held 20 cycles.
  - Expect ld_gnt = 0 throughout, mem_web = 1 throughout.
- Conflict, IMEM_ARB_FAIR_EN with MAX_WAIT = 8: same stimulus as the previous case.
  - Expect ld_gnt = 1 and fetch_gnt = 0 on cycle 9, fetch regranted on cycle 10, then the pattern repeats every 9 cycles.
- Reset mid-read: assert rst in the cycle fetch_gnt = 1.
  - Expect fetch_valid = 0 the next cycle, cpu_hold = 1, and state back to BOOT (fetch_req no longer granted).
